flit_injector: RTL and testbench
================================

FLIT_INJECTOR -- requirements
Module: flit_injector

Interface
REQ-001 SHALL have parameter MAXVC, default 4, number of virtual channels (VC_W = clog2(MAXVC)).
REQ-002 SHALL have parameter DST_W, default 4, destination router id width.
REQ-003 SHALL have parameter NFLIT_W, default 4, packet-length field width.
REQ-004 SHALL have parameter DEPTH, default 8, descriptor FIFO entries (power of two).
REQ-005 SHALL have ports: clk input 1, sole clock, rising edge; rst_n input 1, asynchronous active-low reset.
REQ-006 SHALL have ports: desc_valid input 1, descriptor offered; desc_ready output 1, FIFO can accept.
REQ-007 SHALL have ports: desc_dst input DST_W; desc_vc input VC_W; desc_nflit input NFLIT_W, flits in packet.
REQ-008 SHALL have port can_inject input MAXVC, per-VC credit-available flags from the router injection port.
REQ-009 SHALL have ports: flit_valid output 1; flit_out output 2+VC_W+DST_W+16, {head,tail,vc,dst,payload[15:0]}.
REQ-010 SHALL have ports: busy output 1, packet in flight or FIFO non-empty; pkts_sent output 16, completed-packet count.

Function
REQ-011 SHALL accept a descriptor on a rising edge where desc_valid && desc_ready; desc_ready = !full, independent of pop.
REQ-012 SHALL ignore desc_valid while full; no state change, no overwrite.
REQ-013 SHALL run FSM IDLE, SEND: IDLE with FIFO non-empty pops head entry into cur_dst/cur_vc/cur_len, cur_idx=0, -> SEND next cycle.
REQ-014 SHALL in SEND, on a cycle with can_inject[cur_vc]=1, register one flit so flit_valid=1 the next cycle for exactly one cycle.
REQ-015 SHALL in SEND with can_inject[cur_vc]=0 drive flit_valid=0 and hold cur_idx; no flit dropped or duplicated.
REQ-016 SHALL set head=1 when cur_idx=0, tail=1 when cur_idx=cur_len-1; vc=cur_vc, dst=cur_dst on every flit.
REQ-017 SHALL set body/tail payload = cur_idx zero-extended to 16 bits.
REQ-018 SHALL treat desc_nflit=0 as length 1 (single flit, head=tail=1).
REQ-019 SHALL on issuing the tail flit increment pkts_sent (wraps 0xFFFF->0) and go to IDLE, or pop next entry directly to SEND if FIFO non-empty (back-to-back, no bubble).
REQ-020 SHALL allow a push and an internal pop in the same cycle at any occupancy, including full (pop frees slot only from the next cycle).
REQ-021 SHALL wrap FIFO read/write pointers modulo DEPTH with an extra bit for full/empty discrimination.
REQ-022 SHALL assert busy when FSM is SEND or FIFO non-empty.
REQ-023 SHALL never interleave flits of two packets; at most one packet in flight.

Reset
REQ-024 SHALL on rst_n=0 immediately clear: flit_valid=0, flit_out=0, pkts_sent=0, FIFO empty, FSM=IDLE, busy=0, desc_ready=1.
REQ-025 SHALL abandon a packet in flight if reset asserts mid-packet; no tail flit emitted afterwards.
REQ-026 SHALL resume operation on the first rising clk edge after rst_n deasserts.

Configuration
REQ-027 SHALL honour macro INJ_TIMESTAMP_EN: when defined, a 16-bit free-running cycle counter (reset 0, wraps) is kept and head-flit payload = counter value at the cycle the head is registered.
REQ-028 SHALL when INJ_TIMESTAMP_EN is undefined, omit the counter and set head-flit payload = pkts_sent value at issue time.

Verification
REQ-029 SHALL cover: push {dst=3,vc=1,nflit=3}, can_inject=4'b1111 -> 3 consecutive flits, head/-/tail, payloads {x,1,2}, pkts_sent=1.
REQ-030 SHALL cover: same packet with can_inject[1]=0 for 5 cycles after head -> flit_valid low 5 cycles, flits 1 and 2 then emitted, no repeat.
REQ-031 SHALL cover: push 9 descriptors back-to-back with can_inject=0, DEPTH=8 -> desc_ready low after 8th, 9th ignored, 8 packets later delivered in order.
REQ-032 SHALL cover: nflit=0 and nflit=1 descriptors -> each one flit with head=tail=1, pkts_sent=2.
REQ-033 SHALL cover: rst_n low during flit 2 of a 4-flit packet -> flit_valid=0 immediately, busy=0, pkts_sent=0, no tail seen.
REQ-034 SHALL cover: INJ_TIMESTAMP_EN defined, head registered 10 cycles after reset release -> head payload=10; undefined -> head payload=pkts_sent.

Source files
------------

// File: rtl/flit_injector.sv
// flit_injector: queues packet descriptors in a small FIFO and turns each one
// into a stream of flits for a router injection port, one flit per cycle
// while the packet's virtual channel has credit.
// Optional feature: define INJ_TIMESTAMP_EN to stamp head flits with a
// free-running 16-bit cycle counter instead of the completed-packet count.
module flit_injector #(
    parameter int MAXVC    = 4,
    parameter int DST_W    = 4,
    parameter int NFLIT_W  = 4,
    parameter int DEPTH    = 8,
    localparam int VC_W    = (MAXVC > 1) ? $clog2(MAXVC) : 1,
    localparam int FLIT_W  = 2 + VC_W + DST_W + 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              desc_valid,
    output logic              desc_ready,
    input  logic [DST_W-1:0]  desc_dst,
    input  logic [VC_W-1:0]   desc_vc,
    input  logic [NFLIT_W-1:0] desc_nflit,
    input  logic [MAXVC-1:0]  can_inject,
    output logic              flit_valid,
    output logic [FLIT_W-1:0] flit_out,
    output logic              busy,
    output logic [15:0]       pkts_sent
);

    localparam int AW     = $clog2(DEPTH);
    localparam int DESC_W = DST_W + VC_W + NFLIT_W;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    // Descriptor storage and pointers (extra MSB separates full from empty)
    logic [DESC_W-1:0]  mem_q [DEPTH];
    logic [AW:0]        wr_ptr_q, wr_ptr_d;
    logic [AW:0]        rd_ptr_q, rd_ptr_d;

    // Packet currently being sent; cur_last holds (length - 1)
    state_e             state_q, state_d;
    logic [DST_W-1:0]   cur_dst_q, cur_dst_d;
    logic [VC_W-1:0]    cur_vc_q, cur_vc_d;
    logic [NFLIT_W-1:0] cur_last_q, cur_last_d;
    logic [NFLIT_W-1:0] cur_idx_q, cur_idx_d;

    logic [15:0]        pkts_sent_q, pkts_sent_d;
    logic               flit_valid_q, flit_valid_d;
    logic [FLIT_W-1:0]  flit_out_q, flit_out_d;

    logic               empty_s, full_s, push_s, pop_s;
    logic               issue_s, head_s, tail_s, adv_s;
    logic [15:0]        head_payload_s, payload_s;
    logic [DST_W-1:0]   ent_dst_s;
    logic [VC_W-1:0]    ent_vc_s;
    logic [NFLIT_W-1:0] ent_nflit_s;

    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // Ready depends only on occupancy, never on a same-cycle pop
    assign push_s  = desc_valid && !full_s;
    assign {ent_dst_s, ent_vc_s, ent_nflit_s} = mem_q[rd_ptr_q[AW-1:0]];

    assign issue_s = (state_q == ST_SEND) && can_inject[cur_vc_q];
    assign head_s  = (cur_idx_q == '0);
    assign tail_s  = (cur_idx_q == cur_last_q);
    assign adv_s   = issue_s && !tail_s;

`ifdef INJ_TIMESTAMP_EN
    logic [15:0] ts_q, ts_d;

    assign ts_d           = ts_q + 16'd1;
    assign head_payload_s = ts_q;

    // Free-running cycle counter used to timestamp head flits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q <= 16'd0;
        end else begin
            ts_q <= ts_d;
        end
    end
`else
    assign head_payload_s = pkts_sent_q;
`endif

    assign payload_s = head_s ? head_payload_s : 16'(cur_idx_q);

    // FIFO pointer advance on accepted push and internal pop
    always_comb begin
        wr_ptr_d = push_s ? (wr_ptr_q + (AW+1)'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + (AW+1)'(1)) : rd_ptr_q;
    end

    // Descriptor storage write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {desc_dst, desc_vc, desc_nflit};
        end else begin
            mem_q <= mem_q;
        end
    end

    // FSM next state, pop decision, flit build and packet counter
    always_comb begin
        state_d      = state_q;
        pop_s        = 1'b0;
        flit_valid_d = 1'b0;
        flit_out_d   = '0;
        pkts_sent_d  = pkts_sent_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (issue_s) begin
                    flit_valid_d = 1'b1;
                    flit_out_d   = {head_s, tail_s, cur_vc_q, cur_dst_q, payload_s};
                    if (tail_s) begin
                        pkts_sent_d = pkts_sent_q + 16'd1;
                        // Chain straight into the next packet when one is queued
                        pop_s       = !empty_s;
                        state_d     = empty_s ? ST_IDLE : ST_SEND;
                    end else begin
                        state_d = ST_SEND;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Current-packet context: load on pop, advance index on each non-tail flit
    always_comb begin
        if (pop_s) begin
            cur_dst_d  = ent_dst_s;
            cur_vc_d   = ent_vc_s;
            cur_last_d = (ent_nflit_s == '0) ? '0 : (ent_nflit_s - NFLIT_W'(1));
            cur_idx_d  = '0;
        end else begin
            cur_dst_d  = cur_dst_q;
            cur_vc_d   = cur_vc_q;
            cur_last_d = cur_last_q;
            cur_idx_d  = adv_s ? (cur_idx_q + NFLIT_W'(1)) : cur_idx_q;
        end
    end

    // State register; reset abandons any packet in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            state_q      <= ST_IDLE;
            cur_dst_q    <= '0;
            cur_vc_q     <= '0;
            cur_last_q   <= '0;
            cur_idx_q    <= '0;
            pkts_sent_q  <= 16'd0;
            flit_valid_q <= 1'b0;
            flit_out_q   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            state_q      <= state_d;
            cur_dst_q    <= cur_dst_d;
            cur_vc_q     <= cur_vc_d;
            cur_last_q   <= cur_last_d;
            cur_idx_q    <= cur_idx_d;
            pkts_sent_q  <= pkts_sent_d;
            flit_valid_q <= flit_valid_d;
            flit_out_q   <= flit_out_d;
        end
    end

    assign desc_ready = !full_s;
    assign busy       = (state_q == ST_SEND) || !empty_s;
    assign pkts_sent  = pkts_sent_q;
    assign flit_valid = flit_valid_q;
    assign flit_out   = flit_out_q;

endmodule

// File: tb/tb_flit_injector.sv
// Bench for flit_injector: a queue-based reference model checks every cycle,
// a packet table and directed sequences cover the corner cases, then random
// traffic runs against the same model.
module tb_flit_injector;

    localparam int MAXVC   = 4;
    localparam int VC_W    = 2;
    localparam int DST_W   = 4;
    localparam int NFLIT_W = 4;
    localparam int DEPTH   = 8;
    localparam int FW      = 2 + VC_W + DST_W + 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               desc_valid = 1'b0;
    logic               desc_ready;
    logic [DST_W-1:0]   desc_dst = '0;
    logic [VC_W-1:0]    desc_vc = '0;
    logic [NFLIT_W-1:0] desc_nflit = '0;
    logic [MAXVC-1:0]   can_inject = '0;
    logic               flit_valid;
    logic [FW-1:0]      flit_out;
    logic               busy;
    logic [15:0]        pkts_sent;

    flit_injector #(
        .MAXVC(MAXVC), .DST_W(DST_W), .NFLIT_W(NFLIT_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_dst(desc_dst), .desc_vc(desc_vc), .desc_nflit(desc_nflit),
        .can_inject(can_inject),
        .flit_valid(flit_valid), .flit_out(flit_out),
        .busy(busy), .pkts_sent(pkts_sent)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Head payload differs between builds; compare it only in the default one
    function automatic logic [FW-1:0] hmask(input logic [FW-1:0] w);
`ifdef INJ_TIMESTAMP_EN
        return w[FW-1] ? {w[FW-1:16], 16'h0000} : w;
`else
        return w;
`endif
    endfunction

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [DST_W-1:0]   dst;
        logic [VC_W-1:0]    vc;
        logic [NFLIT_W-1:0] nf;
    } desc_t;

    desc_t         mq[$];
    bit            m_inf;
    desc_t         m_cur;
    int            m_idx, m_len;
    logic [15:0]   m_pk, m_ts, m_pl;
    bit            m_v, m_acc, m_hd, m_tl, m_rst;
    logic [FW-1:0] m_word;

    // Model: packets in a queue, one in flight, one flit per credited cycle
    always @(posedge clk) begin
        m_rst = !rst_n;
        if (m_rst) begin
            mq.delete();
            m_inf = 0; m_idx = 0; m_len = 0;
            m_pk = 16'd0; m_ts = 16'd0; m_v = 0; m_word = '0;
        end else begin
            m_acc = desc_valid && (mq.size() < DEPTH);
            m_v = 0;
            m_word = '0;
            if (m_inf && can_inject[m_cur.vc]) begin
                m_hd = (m_idx == 0);
                m_tl = (m_idx == m_len - 1);
`ifdef INJ_TIMESTAMP_EN
                m_pl = m_hd ? m_ts : 16'(m_idx);
`else
                m_pl = m_hd ? m_pk : 16'(m_idx);
`endif
                m_v = 1;
                m_word = {m_hd, m_tl, m_cur.vc, m_cur.dst, m_pl};
                if (m_tl) begin
                    m_pk = m_pk + 16'd1;
                    m_inf = 0;
                end else begin
                    m_idx++;
                end
            end
            if (!m_inf && mq.size() > 0) begin
                m_cur = mq.pop_front();
                m_inf = 1;
                m_idx = 0;
                m_len = (m_cur.nf == 4'd0) ? 1 : int'(m_cur.nf);
            end
            if (m_acc) mq.push_back({desc_dst, desc_vc, desc_nflit});
            m_ts = m_ts + 16'd1;
        end
        #1;
        chk("mdl_flit_valid", 32'(flit_valid), 32'(m_v));
        if (m_v || m_rst) chk("mdl_flit_out", 32'(flit_out), 32'(m_word));
        chk("mdl_desc_ready", 32'(desc_ready), 32'(mq.size() < DEPTH));
        chk("mdl_busy", 32'(busy), 32'(m_inf || (mq.size() != 0)));
        chk("mdl_pkts_sent", 32'(pkts_sent), 32'(m_pk));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] d, input logic [1:0] v, input logic [3:0] n);
        @(negedge clk);
        desc_valid = 1'b1; desc_dst = d; desc_vc = v; desc_nflit = n;
        @(negedge clk);
        desc_valid = 1'b0;
    endtask

    typedef struct {
        logic [3:0]    dst;
        logic [1:0]    vc;
        logic [3:0]    nf;
        int            exp_n;
        logic [FW-1:0] exp_first;
        logic [FW-1:0] exp_last;
        logic [15:0]   exp_pk;
    } vec_t;

    vec_t          tbl[5];
    int            cnt, fc, lc, lows;
    bit            found;
    logic [FW-1:0] first_w, last_w;
    logic [3:0]    got_dst[$];
    logic [15:0]   pls[$];
    bit            rdy[9];

    initial begin
        // {dst, vc, nflit, flits, first word, last word, pkts_sent after}
        tbl[0] = '{4'd3,  2'd1, 4'd3,  3,  24'h930000, 24'h530002, 16'd1};
        tbl[1] = '{4'd5,  2'd2, 4'd0,  1,  24'hE50001, 24'hE50001, 16'd2};
        tbl[2] = '{4'd0,  2'd0, 4'd1,  1,  24'hC00002, 24'hC00002, 16'd3};
        tbl[3] = '{4'd15, 2'd3, 4'd2,  2,  24'hBF0003, 24'h7F0001, 16'd4};
        tbl[4] = '{4'd10, 2'd2, 4'd15, 15, 24'hAA0004, 24'h6A000E, 16'd5};

        // Reset state, checked while reset is held
        #7;
        chk("rst_flit_valid", 32'(flit_valid), 32'd0);
        chk("rst_desc_ready", 32'(desc_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Packet table, full credit
        can_inject = 4'hF;
        for (int t = 0; t < 5; t++) begin
            push(tbl[t].dst, tbl[t].vc, tbl[t].nf);
            cnt = 0; fc = 0; lc = 0; first_w = '0; last_w = '0;
            for (int c = 0; c < 25; c++) begin
                tick();
                if (flit_valid) begin
                    if (cnt == 0) begin
                        first_w = flit_out;
                        fc = c;
                    end
                    last_w = flit_out;
                    lc = c;
                    cnt++;
                end
            end
            chk($sformatf("tbl%0d_count", t), 32'(cnt), 32'(tbl[t].exp_n));
            chk($sformatf("tbl%0d_first", t), 32'(hmask(first_w)), 32'(hmask(tbl[t].exp_first)));
            chk($sformatf("tbl%0d_last", t), 32'(hmask(last_w)), 32'(hmask(tbl[t].exp_last)));
            chk($sformatf("tbl%0d_span", t), 32'(lc - fc), 32'(tbl[t].exp_n - 1));
            chk($sformatf("tbl%0d_pkts", t), 32'(pkts_sent), 32'(tbl[t].exp_pk));
        end

        // Credit withdrawn on VC1 for 5 cycles right after the head flit
        push(4'd3, 2'd1, 4'd3);
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            tick();
            if (flit_valid) found = 1;
        end
        chk("stall_head_seen", 32'(found), 32'd1);
        @(negedge clk);
        can_inject = 4'b1101;
        lows = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (!flit_valid) lows++;
        end
        @(negedge clk);
        can_inject = 4'hF;
        pls.delete();
        for (int c = 0; c < 6; c++) begin
            tick();
            if (flit_valid) pls.push_back(flit_out[15:0]);
        end
        chk("stall_low_cycles", 32'(lows), 32'd5);
        chk("stall_rest_count", 32'(pls.size()), 32'd2);
        if (pls.size() == 2) begin
            chk("stall_pl1", 32'(pls[0]), 32'd1);
            chk("stall_pl2", 32'(pls[1]), 32'd2);
        end
        chk("stall_pkts", 32'(pkts_sent), 32'd6);

        // FIFO full: one packet blocked in flight, then 9 pushes back-to-back
        can_inject = 4'h0;
        push(4'd15, 2'd0, 4'd1);
        tick();
        tick();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            desc_valid = 1'b1;
            desc_dst = 4'(i);
            desc_vc = 2'(i);
            desc_nflit = 4'd1;
            tick();
            rdy[i] = desc_ready;
        end
        @(negedge clk);
        desc_valid = 1'b0;
        chk("full_ready_7th", 32'(rdy[6]), 32'd1);
        chk("full_ready_8th", 32'(rdy[7]), 32'd0);
        chk("full_ready_9th", 32'(rdy[8]), 32'd0);
        can_inject = 4'hF;
        got_dst.delete();
        for (int c = 0; c < 40; c++) begin
            tick();
            if (flit_valid) got_dst.push_back(flit_out[19:16]);
        end
        chk("full_delivered", 32'(got_dst.size()), 32'd9);
        if (got_dst.size() == 9) begin
            chk("full_order_blk", 32'(got_dst[0]), 32'd15);
            for (int i = 1; i < 9; i++) chk($sformatf("full_order_%0d", i), 32'(got_dst[i]), 32'(i - 1));
        end
        chk("full_pkts", 32'(pkts_sent), 32'd15);

        // Reset during the second flit of a 4-flit packet
        push(4'd2, 2'd0, 4'd4);
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            tick();
            if (flit_valid && !flit_out[FW-1] && flit_out[15:0] == 16'd1) found = 1;
        end
        chk("rst_mid_seen", 32'(found), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(flit_valid), 32'd0);
        chk("rst_mid_out", 32'(flit_out), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_pkts", 32'(pkts_sent), 32'd0);
        chk("rst_mid_ready", 32'(desc_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (flit_valid) cnt++;
        end
        chk("rst_mid_no_tail", 32'(cnt), 32'd0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            desc_valid = ($urandom_range(0, 2) == 0);
            desc_dst   = 4'($urandom);
            desc_vc    = 2'($urandom);
            desc_nflit = 4'($urandom_range(0, 6));
            can_inject = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
        end
        @(negedge clk);
        desc_valid = 1'b0;
        can_inject = 4'hF;
        repeat (200) @(negedge clk);
        chk("drain_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
